// File: rtl/sprite_dma_pkg.sv
// Shared video package: sprite DMA state encoding and default transfer geometry.
package sprite_dma_pkg;

  typedef enum logic [2:0] {IDLE, REQ, XFER, DRAIN, DONE} dma_state_t;

  localparam int SPR_DMA_LEN      = 384;
  localparam int SPR_DMA_DST_BASE = 0;

endpackage

// File: rtl/sprite_dma.sv
// Sprite-attribute DMA: requests the CPU bus, then copies LEN bytes from work RAM into object RAM.
// One byte per clock once granted; losing the grant pauses the copy and re-reads the byte in flight.
module sprite_dma
  import sprite_dma_pkg::*;
#(
  parameter int SRC_AW   = 11,
  parameter int DST_AW   = 8,
  parameter int LEN      = SPR_DMA_LEN,
  parameter int DST_BASE = SPR_DMA_DST_BASE
) (
  input  logic              I_CLK,
  input  logic              I_RST_n,
  input  logic              I_START,
  input  logic [SRC_AW-1:0] I_SRC_BASE,
  input  logic              I_BUSAK_n,
  output logic              O_BUSRQ_n,
  output logic [SRC_AW-1:0] O_SRC_ADDR,
  output logic              O_SRC_CE,
  input  logic [7:0]        I_SRC_D,
  output logic [DST_AW-1:0] O_DST_ADDR,
  output logic [7:0]        O_DST_D,
  output logic              O_DST_CE,
  output logic              O_DST_WE,
  output logic              O_BUSY,
  output logic              O_DONE
);

  localparam int            CW   = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  dma_state_t        state;
  logic [SRC_AW-1:0] base;
  logic [CW-1:0]     rd;
  logic [CW-1:0]     wr;
  logic              pv;
  logic              grant;
  logic              moving;

  assign grant  = ~I_BUSAK_n;
  // Bus cycles only happen while the grant is held; a dropped grant gates them off in that same cycle.
  assign moving = grant && (state == XFER || state == DRAIN);

  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      state <= IDLE;
      base  <= '0;
      rd    <= '0;
      wr    <= '0;
      pv    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (I_START) begin
            base  <= I_SRC_BASE;
            rd    <= '0;
            wr    <= '0;
            pv    <= 1'b0;
            state <= REQ;
          end
        end
        REQ: begin
          if (grant) state <= XFER;
        end
        XFER: begin
          if (!grant) begin
            pv <= 1'b0;
            rd <= wr;
          end else begin
            if (pv) wr <= wr + 1'b1;
            rd <= rd + 1'b1;
            pv <= 1'b1;
            if (rd == LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The last byte is only committed if the grant survives this cycle.
          if (!grant) begin
            pv    <= 1'b0;
            rd    <= wr;
            state <= XFER;
          end else begin
            wr    <= wr + 1'b1;
            pv    <= 1'b0;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign O_SRC_ADDR = base + SRC_AW'(rd);
  assign O_SRC_CE   = moving;
  assign O_DST_ADDR = DST_AW'(DST_BASE) + DST_AW'(wr);
  assign O_DST_D    = I_SRC_D;
  assign O_DST_WE   = moving && pv;
  assign O_DST_CE   = O_DST_WE;
  assign O_BUSY     = (state != IDLE);
  assign O_DONE     = (state == DONE);
  assign O_BUSRQ_n  = !(state == REQ || state == XFER || state == DRAIN);

endmodule

// File: tb/tb_sprite_dma.sv
// Bench for sprite_dma: work-RAM model, object-RAM write scoreboard, table of transfer scenarios
// plus hand-written reset sequences.
module tb_sprite_dma;

  localparam int SRC_AW = 11;
  localparam int DST_AW = 9;
  localparam int LEN    = 384;

  typedef struct packed {
    logic [DST_AW-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  typedef struct {
    string             name;
    logic [SRC_AW-1:0] base;
    int                gdelay;
    int                drop_after;
    int                drop_len;
    int                start_at;
    int                exp_done;
    int                exp_ce;
    logic [SRC_AW-1:0] exp_rd16;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [SRC_AW-1:0] src_base;
  logic              busak_n;
  logic              busrq_n;
  logic [SRC_AW-1:0] src_addr;
  logic              src_ce;
  logic [7:0]        src_d = 8'h00;
  logic [DST_AW-1:0] dst_addr;
  logic [7:0]        dst_d;
  logic              dst_ce;
  logic              dst_we;
  logic              busy;
  logic              done;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int ce_cnt  = 0;
  int viol    = 0;
  logic [SRC_AW-1:0] rd_log[$];
  wr_t               sb[$];
  vec_t              vecs[5];

  sprite_dma #(
    .SRC_AW(SRC_AW), .DST_AW(DST_AW), .LEN(LEN), .DST_BASE(0)
  ) dut (
    .I_CLK(clk), .I_RST_n(rst_n), .I_START(start), .I_SRC_BASE(src_base),
    .I_BUSAK_n(busak_n), .O_BUSRQ_n(busrq_n), .O_SRC_ADDR(src_addr), .O_SRC_CE(src_ce),
    .I_SRC_D(src_d), .O_DST_ADDR(dst_addr), .O_DST_D(dst_d), .O_DST_CE(dst_ce),
    .O_DST_WE(dst_we), .O_BUSY(busy), .O_DONE(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Work RAM: synchronous read, contents addr[7:0] ^ 0x5A.
  always @(posedge clk) if (src_ce) src_d <= src_addr[7:0] ^ 8'h5A;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (src_ce) begin
      rd_log.push_back(src_addr);
      ce_cnt++;
    end
    if (busak_n && (src_ce || dst_ce || dst_we)) viol++;
    if (dst_ce || dst_we) begin
      check("dst_ce_eq_we", 32'(dst_ce), 32'(dst_we));
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL extra_write: write to 0x%0h data 0x%0h, expected none", dst_addr, dst_d);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(dst_addr), 32'(e.addr));
        check("wr_data", 32'(dst_d), 32'(e.data));
      end
    end
  end

  task automatic push_expected(input logic [SRC_AW-1:0] b);
    logic [SRC_AW-1:0] a;
    wr_t w;
    for (int i = 0; i < LEN; i++) begin
      a      = b + SRC_AW'(i);
      w.addr = DST_AW'(i);
      w.data = a[7:0] ^ 8'h5A;
      sb.push_back(w);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ":busrq_n"}, 32'(busrq_n), 32'd1);
    check({tag, ":busy"}, 32'(busy), 32'd0);
    check({tag, ":done"}, 32'(done), 32'd0);
    check({tag, ":src_ce"}, 32'(src_ce), 32'd0);
    check({tag, ":dst_ce"}, 32'(dst_ce), 32'd0);
    check({tag, ":dst_we"}, 32'(dst_we), 32'd0);
    check({tag, ":src_addr"}, 32'(src_addr), 32'd0);
    check({tag, ":dst_addr"}, 32'(dst_addr), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int c0;
    int hold     = 0;
    int done_cnt = 0;
    bit dropped  = 0;
    bit timeout  = 0;
    push_expected(v.base);
    @(posedge clk); #1;
    rd_log.delete();
    ce_cnt   = 0;
    viol     = 0;
    c0       = cyc;
    start    = 1'b1;
    src_base = v.base;
    busak_n  = (v.gdelay == 0) ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({v.name, ":req_busrq_n"}, 32'(busrq_n), 32'd0);
    check({v.name, ":req_busy"}, 32'(busy), 32'd1);
    for (int k = 0; k < v.gdelay; k++) begin
      @(posedge clk); #1;
    end
    busak_n = 1'b0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (cyc - c0 > 1500) begin
        timeout = 1;
        break;
      end
      if (!dropped && v.drop_after >= 0 && dst_we && int'(dst_addr) == v.drop_after) begin
        dropped = 1;
        hold    = v.drop_len;
      end
      @(posedge clk); #1;
      busak_n = (hold > 0);
      if (hold > 0) hold--;
      start    = (v.start_at >= 0 && cyc - c0 == v.start_at);
      src_base = start ? 11'h3FF : v.base;
    end
    check({v.name, ":timeout"}, 32'(timeout), 32'd0);
    check({v.name, ":done_cycle"}, 32'(cyc - c0), 32'(v.exp_done));
    check({v.name, ":done_busrq_n"}, 32'(busrq_n), 32'd1);
    done_cnt = done ? 1 : 0;
    busak_n  = 1'b1;
    start    = 1'b0;
    @(negedge clk);
    check({v.name, ":idle_busy"}, 32'(busy), 32'd0);
    check({v.name, ":idle_done"}, 32'(done), 32'd0);
    repeat (4) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check({v.name, ":done_count"}, 32'(done_cnt), 32'd1);
    check({v.name, ":sb_empty"}, 32'(sb.size()), 32'd0);
    check({v.name, ":ce_cycles"}, 32'(ce_cnt), 32'(v.exp_ce));
    check({v.name, ":no_ce_without_grant"}, 32'(viol), 32'd0);
    check({v.name, ":rd0"}, rd_log.size() > 0 ? 32'(rd_log[0]) : 32'hFFFF_FFFF, 32'(v.base));
    check({v.name, ":rd16"}, rd_log.size() > 16 ? 32'(rd_log[16]) : 32'hFFFF_FFFF, 32'(v.exp_rd16));
  endtask

  initial begin
    bit found;
    vecs[0] = '{"basic",     11'h100, 0,  -1,  0, -1, 387, 385, 11'h110};
    vecs[1] = '{"grant_lat", 11'h100, 10, -1,  0, -1, 397, 385, 11'h110};
    vecs[2] = '{"grant_drop", 11'h100, 0, 100, 3, -1, 391, 386, 11'h110};
    vecs[3] = '{"src_wrap",  11'h7F0, 0,  -1,  0, -1, 387, 385, 11'h000};
    vecs[4] = '{"start_busy", 11'h100, 0, -1,  0, 52, 387, 385, 11'h110};

    rst_n    = 1'b0;
    start    = 1'b0;
    src_base = '0;
    busak_n  = 1'b1;
    #3;
    check_reset_vals("reset");
    #9;
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while byte 200 is being written, then a fresh transfer must complete.
    push_expected(11'h100);
    @(posedge clk); #1;
    start    = 1'b1;
    src_base = 11'h100;
    busak_n  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      if (dst_we && dst_addr == 9'd200) found = 1;
    end
    check("rst_mid:reached_byte200", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("rst_mid");
    sb.delete();
    @(posedge clk); #3;
    rst_n   = 1'b1;
    busak_n = 1'b1;
    vecs[0].name = "after_reset";
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sprite_dma.md
# sprite_dma

Sprite-attribute DMA engine for the video subsystem. On a start strobe it acquires the CPU bus via a BUSRQ/BUSAK handshake. It then copies a fixed-length block from CPU work RAM (port B of `ram_2048_8_8`) into object RAM (port A of `ram_2EF`), one byte per clock, and releases the bus. It replaces the discrete 8257 DMA path and sits directly upstream of the object RAM that the sprite line-buffer logic reads.

## Interface
Parameters:
- `SRC_AW`, 11: source address width.
- `DST_AW`, 8: destination address width.
- `LEN`, 384: bytes per transfer.
  - Legal range is 1 ≤ LEN ≤ 2^DST_AW, so the default 384 is legal only with DST_AW ≥ 9. With DST_AW = 8, LEN must be set to 256 or less.
- `DST_BASE`, 0: first destination address.

Ports:
- `I_CLK` in 1: system clock. Single clock domain.
- `I_RST_n` in 1: reset, asynchronous and active-low.
- `I_START` in 1: transfer request, sampled high for one cycle.
- `I_SRC_BASE` in SRC_AW: source start address, latched at start.
- `I_BUSAK_n` in 1: CPU bus acknowledge, active-low.
- `O_BUSRQ_n` out 1: CPU bus request, active-low.
- `O_SRC_ADDR` out SRC_AW: source RAM address.
- `O_SRC_CE` out 1: source chip enable; the same signal drives OE.
- `I_SRC_D` in 8: source read data, valid one cycle after the address.
- `O_DST_ADDR` out DST_AW: destination RAM address.
- `O_DST_D` out 8: destination write data.
- `O_DST_CE` out 1: destination chip enable.
- `O_DST_WE` out 1: destination write enable.
- `O_BUSY` out 1: high in any state except IDLE.
- `O_DONE` out 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: `I_START`=1 latches `I_SRC_BASE`, clears rd=0 and wr=0, and moves to REQ.
  - REQ: `O_BUSRQ_n`=0. `I_BUSAK_n`=0 moves to XFER.
  - XFER, per cycle with grant held:
    - `O_SRC_ADDR` = base+rd, `O_SRC_CE`=1.
    - If the pending flag `pv` is set: write `I_SRC_D` to DST_BASE+wr, then wr++.
    - rd++ and pv=1.
    - When the cycle issues rd=LEN-1, the next state is DRAIN.
  - DRAIN: `O_SRC_CE`=1 (keeps data gated through), write the last byte, then go to DONE.
  - DONE: `O_BUSRQ_n`=1 and `O_DONE`=1, then back to IDLE.
- Arithmetic:
  - The source address is base+rd modulo 2^SRC_AW, wrapping silently.
  - The destination address is DST_BASE+wr modulo 2^DST_AW.
  - Counters are wide enough to hold LEN.
- `O_DST_D` is a combinational pass-through of `I_SRC_D`. `O_DST_CE` equals `O_DST_WE`, and both are high only on write cycles.
- Grant loss during XFER (`I_BUSAK_n`=1) pauses the transfer:
  - No CE or WE is asserted.
  - The byte in flight is discarded: pv=0 and rd is rewound to wr.
  - `O_BUSRQ_n` stays 0, and XFER resumes when the grant returns.
- Grant loss during DRAIN is handled the same way: the last byte is discarded, rd is rewound to wr, and the state returns to XFER.
- `I_START` in any state other than IDLE is ignored. No queueing is done.
- Asynchronous reset at any point returns to IDLE. Reset values: `O_BUSRQ_n`=1, `O_BUSY`=0, `O_DONE`=0, `O_SRC_CE`=0, `O_DST_CE`=0, `O_DST_WE`=0, `O_SRC_ADDR`=0, `O_DST_ADDR`=DST_BASE. A partial copy is left as written.

## Timing
- Cycle 0: START is sampled. Cycle 1: REQ, with `O_BUSRQ_n`=0.
- Grant sampled low in cycle g: XFER runs from g+1 to g+LEN, and DRAIN is cycle g+LEN+1.
  - Byte i is read at g+1+i and written at g+2+i.
- DONE is cycle g+LEN+2, with `O_DONE`=1 and `O_BUSRQ_n`=1. The block is in IDLE at g+LEN+3.
- Throughput is 1 byte per clock. Each pause adds its own length plus one re-read cycle.
- A new START is accepted in the IDLE cycle after DONE.

## Structure
- Shared video package holds:
  - the state enum `{IDLE, REQ, XFER, DRAIN, DONE}`;
  - the constants `SPR_DMA_LEN`=384 and `SPR_DMA_DST_BASE`=0.
- Single module with no sub-module. The rd/wr counters and the FSM are inline.

## Test plan
- Basic copy: use SRC_AW=11, DST_AW=9, LEN=384, with `I_BUSAK_n` tied low and a source RAM model seeded with data = addr[7:0]^8'h5A. Issue START with base 0x100. Required: destination bytes 0..383 match the seeded values, and `O_DONE` fires exactly at g+386.
- Grant latency: hold `I_BUSAK_n` high for 10 cycles after BUSRQ. Required: no CE or WE is asserted before the grant, and the copy is otherwise identical to the basic copy.
- Mid-transfer grant drop: raise BUSAK_n for 3 cycles after byte 100 is written. Required: byte 101 is re-read, no duplicate or missing writes occur, and total duration is 3+1 cycles longer.
- Source wrap: base 0x7F0 with LEN=32. Required: source addresses read run 0x7F0..0x7FF then 0x000..0x00F.
- START while busy: pulse START at XFER cycle 50. Required: it is ignored and only one DONE is produced.
- Reset mid-transfer: assert `I_RST_n` low at XFER byte 200. Required: all outputs immediately take reset values, `O_BUSRQ_n`=1, and a subsequent START completes normally.
